alu_issue_wb: RTL and testbench
===============================

ALU_ISSUE_WB -- requirements
Module: alu_issue_wb

Sequencer between instruction source and the ALU: decodes, reads 16x16 register file, drives ALU operands, writes back result and latches flags into PSR. Instruction word: [15:12] op, [11:8] rd, [7:4] ext, [3:0] rs, imm8 = [7:0].

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk and reset_n.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- instr  in  16  instruction word
- instr_valid  in  1  instr is valid
- instr_ready  out  1  block can accept instr
- alu_A  out  16  ALU operand A
- alu_B  out  16  ALU operand B
- alu_opcode  out  4  to ALU opcode
- alu_opext  out  4  to ALU opext
- alu_S  in  16  ALU result (combinational)
- alu_CLFZN  in  5  ALU flags {C,L,F,Z,N}
- psr  out  5  latched flags
- done  out  1  one-cycle writeback pulse
- dbg_addr  in  4  debug register-file read address
- dbg_data  out  16  R[dbg_addr], combinational

Function
REQ-003 SHALL implement FSM IDLE -> DECODE -> EXEC -> WB -> IDLE, one cycle per state.
REQ-004 instr_ready SHALL be 1 only in IDLE; accept = instr_valid && instr_ready, captures instr, moves to DECODE.
REQ-005 instr_valid in non-IDLE states SHALL be ignored; back-to-back accepts are exactly 4 cycles apart.
REQ-006 Register form SHALL be op==0000, op==1010, or (op==1000 && ext==0100); all other ops are immediate form.
REQ-007 Immediate SHALL be sign-extended imm8 for op 0101, 0111, 1001, 1011, 1101; zero-extended for 0110, 1000, 1110.
REQ-008 In DECODE: alu_A = R[rd], alu_B = R[rs] (register form) or the extended immediate.
REQ-009 Exception: MOV (0000/1101) SHALL drive alu_A = R[rs]; MOVI (op 1101) SHALL drive alu_A = the extended immediate.
REQ-010 alu_A, alu_B, alu_opcode, alu_opext SHALL be registered in DECODE and held stable through WB.
REQ-011 In EXEC, alu_S and alu_CLFZN SHALL be captured into internal result registers.
REQ-012 In WB, R[rd] SHALL be written with the captured result, except for these ops:
- CMP (0000/1011), CMPI (op 1011), CMPU (1010/0010), NOP (0000/0000).
REQ-013 In WB, psr SHALL load the captured flags for every instruction except NOP.
REQ-014 done SHALL pulse high for exactly the WB cycle.
REQ-015 Latency SHALL be 3 cycles: accept edge to the WB edge that makes the write visible on dbg_data.
REQ-016 No hazard logic; a following instruction reads after the prior WB.
REQ-017 R0 SHALL be an ordinary writable register.

Reset
REQ-018 On reset_n=0, asynchronously:
- state = IDLE, instr_ready = 1, done = 0;
- psr, all 16 registers, operand/result registers and captured instr = 0.
REQ-019 Reset in any state SHALL abort the instruction with no register or psr update.

Structure
REQ-020 The FSM state encoding, op/ext constants and the register-form/immediate/no-writeback decode tables SHALL live in a shared package, alu_pkg.
REQ-021 The register file SHALL be one sub-module, regfile16:
- 16x16, async reset, one combinational read port for operands, one for dbg;
- one synchronous write port.

Verification
REQ-022 0xD2FF (MOVI R2), then 0x6201 (ADDUI R2) -> R2=0xFFFF, then R2=0x0000, psr=5'b10000.
REQ-023 0xD105, 0xD303, 0x0193 (SUB R1,R3) -> alu_A=0x0005, alu_B=0x0003, R1=0x0002, done once per instruction.
REQ-024 0xB205 (CMPI R2) after REQ-022 -> R2 stays 0x0000, psr=0, done pulses.
REQ-025 instr_valid held high with 3 instructions -> accepts at cycles 0, 4, 8; instr_ready low on cycles 1-3.
REQ-026 reset_n low during EXEC of 0xD1AA -> R1=0, psr=0, no done, instr_ready=1 the cycle reset releases.
REQ-027 0x04D1 (MOV R4,R1) with R1=0x0002 -> alu_A=0x0002, R4=0x0002.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: FSM state
// encoding, opcode/extension constants and the instruction decode tables
// (register vs immediate form, immediate extension, writeback and PSR
// enables).
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  // Primary opcodes (instr[15:12])
  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_ADDUI = 4'h6;
  localparam logic [3:0] OP_OP7   = 4'h7;
  localparam logic [3:0] OP_OP8   = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_REGA  = 4'hA;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_OPE   = 4'hE;

  // Extension codes (instr[7:4]) used by the decode tables
  localparam logic [3:0] EXT_NOP  = 4'h0;
  localparam logic [3:0] EXT_CMPU = 4'h2;
  localparam logic [3:0] EXT_OP84 = 4'h4;
  localparam logic [3:0] EXT_CMP  = 4'hB;
  localparam logic [3:0] EXT_MOV  = 4'hD;

  function automatic logic is_reg_form(input logic [3:0] op, input logic [3:0] ext);
    return (op == OP_REG) || (op == OP_REGA) || ((op == OP_OP8) && (ext == EXT_OP84));
  endfunction

  // Sign-extend for the signed-immediate ops, zero-extend everything else.
  function automatic logic [15:0] ext_imm(input logic [3:0] op, input logic [7:0] imm8);
    logic sext;
    sext = (op == OP_ADDI) || (op == OP_OP7) || (op == OP_SUBI) ||
           (op == OP_CMPI) || (op == OP_MOVI);
    return sext ? {{8{imm8[7]}}, imm8} : {8'h00, imm8};
  endfunction

  function automatic logic is_mov(input logic [3:0] op, input logic [3:0] ext);
    return (op == OP_REG) && (ext == EXT_MOV);
  endfunction

  function automatic logic is_nop(input logic [3:0] op, input logic [3:0] ext);
    return (op == OP_REG) && (ext == EXT_NOP);
  endfunction

  // Compares and NOP leave the register file untouched.
  function automatic logic no_writeback(input logic [3:0] op, input logic [3:0] ext);
    return ((op == OP_REG) && (ext == EXT_CMP)) || (op == OP_CMPI) ||
           ((op == OP_REGA) && (ext == EXT_CMPU)) || is_nop(op, ext);
  endfunction

endpackage

// File: rtl/alu_issue_wb_regfile16.sv
// regfile16: 16 x 16-bit register file.
// Ports:
//   clk, reset_n        clock, async active-low reset (clears all registers)
//   we, waddr, wdata    synchronous write port
//   raddr_a / rdata_a   combinational operand read port (rd)
//   raddr_b / rdata_b   combinational operand read port (rs)
//   dbg_addr / dbg_data combinational debug read port
module regfile16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [3:0]  raddr_a,
  output logic [15:0] rdata_a,
  input  logic [3:0]  raddr_b,
  output logic [15:0] rdata_b,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  logic [15:0] regs [16];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: four-state sequencer (IDLE -> DECODE -> EXEC -> WB) between
// an instruction source and an external combinational ALU. Decodes the
// captured instruction, reads operands from regfile16, drives registered ALU
// operands, captures the ALU result/flags and writes back R[rd] and psr.
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   instr, instr_valid/ready      instruction handshake (ready only in IDLE)
//   alu_A, alu_B                  registered ALU operands
//   alu_opcode, alu_opext         registered ALU op/ext
//   alu_S, alu_CLFZN              ALU result and flags {C,L,F,Z,N}
//   psr                           latched flags
//   done                          high for the WB cycle
//   dbg_addr / dbg_data           combinational register-file debug read
module alu_issue_wb
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_opext,
  input  logic [15:0] alu_S,
  input  logic [4:0]  alu_CLFZN,
  output logic [4:0]  psr,
  output logic        done,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  state_t      state, state_next;
  logic [15:0] instr_q;
  logic [3:0]  op, rd, ext, rs;
  logic [15:0] imm, rd_val, rs_val, a_next, b_next;
  logic [15:0] res_q;
  logic [4:0]  flags_q;
  logic        accept, wr_en;

  assign op  = instr_q[15:12];
  assign rd  = instr_q[11:8];
  assign ext = instr_q[7:4];
  assign rs  = instr_q[3:0];
  assign imm = ext_imm(op, instr_q[7:0]);

  assign accept = instr_valid && instr_ready;
  // Write lands on the WB->IDLE edge, so a reset during WB still aborts it.
  assign wr_en  = (state == ST_WB) && !no_writeback(op, ext);

  regfile16 u_rf (
    .clk      (clk),
    .reset_n  (reset_n),
    .we       (wr_en),
    .waddr    (rd),
    .wdata    (res_q),
    .raddr_a  (rd),
    .rdata_a  (rd_val),
    .raddr_b  (rs),
    .rdata_b  (rs_val),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_next = ST_DECODE;
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   state_next = ST_WB;
      ST_WB: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    a_next = rd_val;
    b_next = is_reg_form(op, ext) ? rs_val : imm;
    if (is_mov(op, ext)) a_next = rs_val;
    if (op == OP_MOVI)   a_next = imm;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q    <= '0;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_opcode <= '0;
      alu_opext  <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      psr        <= '0;
    end else begin
      if (accept) instr_q <= instr;
      if (state == ST_DECODE) begin
        alu_A      <= a_next;
        alu_B      <= b_next;
        alu_opcode <= op;
        alu_opext  <= ext;
      end
      if (state == ST_EXEC) begin
        res_q   <= alu_S;
        flags_q <= alu_CLFZN;
      end
      if ((state == ST_WB) && !is_nop(op, ext)) psr <= flags_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
module tb_alu_issue_wb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] alu_A, alu_B, alu_S;
  logic [3:0]  alu_opcode, alu_opext;
  logic [4:0]  alu_CLFZN, psr;
  logic        done;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [15:0] last_A, last_B;

  alu_issue_wb dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_A(alu_A), .alu_B(alu_B),
    .alu_opcode(alu_opcode), .alu_opext(alu_opext), .alu_S(alu_S),
    .alu_CLFZN(alu_CLFZN), .psr(psr), .done(done),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (reset_n && done) done_cnt++;

  // Environment ALU: returns {C,L,F,Z,N, S}.
  function automatic logic [20:0] alu_fn(input logic [3:0] op, input logic [3:0] ext,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    logic [4:0]  f;
    logic [15:0] s;
    f = '0;
    s = a | b;
    if ((op == 4'h0 && (ext == 4'h5 || ext == 4'h6)) || op == 4'h5 || op == 4'h6) begin
      sum = {1'b0, a} + {1'b0, b};
      s = sum[15:0];
      f[4] = sum[16];
    end else if ((op == 4'h0 && ext == 4'h9) || op == 4'h9) begin
      s = a - b;
      f[4] = (a < b);
    end else if ((op == 4'h0 && ext == 4'hB) || op == 4'hB || (op == 4'hA && ext == 4'h2)) begin
      s = a;
      f[3] = (a > b);
      f[1] = (a == b);
      f[0] = ($signed(a) > $signed(b));
    end else if ((op == 4'h0 && ext == 4'hD) || op == 4'hD) begin
      s = a;
    end
    return {f, s};
  endfunction

  always_comb {alu_CLFZN, alu_S} = alu_fn(alu_opcode, alu_opext, alu_A, alu_B);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: everything about an instruction is resolved at accept
  // time from architectural state; the compare process then checks the
  // DUT against the timeline "accept, +1 decode, +2 exec, +3 writeback".
  logic [15:0] m_reg [16];
  logic [4:0]  m_psr;
  int          m_k;
  logic [15:0] e_A, e_B, e_S;
  logic [3:0]  e_op, e_ext, e_rd;
  logic [4:0]  e_F;
  logic        e_wr, e_psr;

  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
      m_psr = '0;
      m_k = 0;
    end else begin
      chk("instr_ready", instr_ready, m_k == 0);
      chk("done", done, m_k == 3);
      chk("psr", psr, m_psr);
      chk("dbg_data", dbg_data, m_reg[dbg_addr]);
      if (m_k >= 2) begin
        chk("alu_A", alu_A, e_A);
        chk("alu_B", alu_B, e_B);
        chk("alu_opcode", alu_opcode, e_op);
        chk("alu_opext", alu_opext, e_ext);
      end
      if (m_k == 0) begin
        if (instr_valid) begin
          logic [3:0]  rs;
          logic [15:0] imm;
          logic        regf, sext;
          logic [20:0] r;
          e_op = instr[15:12]; e_rd = instr[11:8]; e_ext = instr[7:4]; rs = instr[3:0];
          regf = (e_op == 4'h0) || (e_op == 4'hA) || (e_op == 4'h8 && e_ext == 4'h4);
          sext = (e_op == 4'h5) || (e_op == 4'h7) || (e_op == 4'h9) || (e_op == 4'hB) || (e_op == 4'hD);
          imm = sext ? {{8{instr[7]}}, instr[7:0]} : {8'h00, instr[7:0]};
          e_A = m_reg[e_rd];
          e_B = regf ? m_reg[rs] : imm;
          if (e_op == 4'h0 && e_ext == 4'hD) e_A = m_reg[rs];
          if (e_op == 4'hD) e_A = imm;
          r = alu_fn(e_op, e_ext, e_A, e_B);
          e_S = r[15:0];
          e_F = r[20:16];
          e_psr = !(e_op == 4'h0 && e_ext == 4'h0);
          e_wr = e_psr && !(e_op == 4'h0 && e_ext == 4'hB) && (e_op != 4'hB) &&
                 !(e_op == 4'hA && e_ext == 4'h2);
          m_k = 1;
        end
      end else if (m_k == 3) begin
        if (e_wr)  m_reg[e_rd] = e_S;
        if (e_psr) m_psr = e_F;
        m_k = 0;
      end else begin
        m_k++;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (instr_ready) break;
      n++;
    end
    if (!instr_ready) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk("done_seen", done, 1);
    last_A = alu_A;
    last_B = alu_B;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [15:0] w);
    @(posedge clk); #1;
    instr = w; instr_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wait_done();
  endtask

  task automatic reg_is(input string name, input logic [3:0] a, input logic [15:0] v);
    dbg_addr = a; #1;
    chk(name, dbg_data, v);
  endtask

  initial begin
    int d0, acc[3];
    logic [15:0] ws [3];
    #3;
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_psr", psr, 0);
    chk("rst_dbg", dbg_data, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // MOVI R2,-1 ; ADDUI R2,1 wraps to zero with carry
    issue(16'hD2FF);
    reg_is("r2_movi", 4'd2, 16'hFFFF);
    issue(16'h6201);
    reg_is("r2_addui", 4'd2, 16'h0000);
    chk("psr_carry", psr, 5'b10000);

    // MOVI R1,5 ; MOVI R3,3 ; SUB R1,R3
    d0 = done_cnt;
    issue(16'hD105);
    issue(16'hD303);
    issue(16'h0193);
    chk("sub_A", last_A, 16'h0005);
    chk("sub_B", last_B, 16'h0003);
    reg_is("r1_sub", 4'd1, 16'h0002);
    chk("done_count", done_cnt - d0, 3);

    // MOV R4,R1
    issue(16'h04D1);
    chk("mov_A", last_A, 16'h0002);
    reg_is("r4_mov", 4'd4, 16'h0002);

    // CMPI R2,5: no writeback, flags all clear
    d0 = done_cnt;
    issue(16'hB205);
    reg_is("r2_cmpi", 4'd2, 16'h0000);
    chk("psr_cmpi", psr, 5'b00000);
    chk("cmpi_done", done_cnt - d0, 1);

    // Back-to-back: instr_valid held high across three ADDI R3
    ws[0] = 16'h5301; ws[1] = 16'h5302; ws[2] = 16'h5303;
    dbg_addr = 4'd3;
    @(posedge clk); #1;
    instr = ws[0]; instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      acc[i] = cyc;
      @(posedge clk); #1;
      if (i < 2) instr = ws[i+1];
      else       instr_valid = 1'b0;
    end
    chk("b2b_gap01", acc[1] - acc[0], 4);
    chk("b2b_gap12", acc[2] - acc[1], 4);
    wait_done();
    reg_is("r3_b2b", 4'd3, 16'h0009);

    // Reset asserted while MOVI R1,0xAA is in EXEC
    @(posedge clk); #1;
    instr = 16'hD1AA; instr_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1 instr_valid = 1'b0;   // DECODE
    @(posedge clk); #1;                      // EXEC
    d0 = done_cnt;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", instr_ready, 1);
    chk("rst_no_done", done_cnt - d0, 0);
    reg_is("r1_abort", 4'd1, 16'h0000);
    chk("psr_abort", psr, 5'b00000);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
